// File: rtl/down_timer5.sv
// down_timer5 -- loadable countdown timer with one-shot / auto-reload modes.
//
// A start value is taken over a valid/ready load handshake, then the count
// decrements on each enabled cycle. When a decrement would take the count
// from 1 to 0, a one-cycle expiry pulse is produced. The timer then stops
// (one-shot) or restarts from the stored start value (auto-reload).
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   en           decrement enable while running (low = hold)
//   stop         synchronous abort to IDLE; beats load and decrement
//   load_valid   load request
//   load_ready   block can accept a load (IDLE and out of reset)
//   load_value   start value, sampled on accept
//   auto_reload  mode, sampled on accept (1 = reload at terminal count)
//   count        remaining count (registered)
//   busy         high while running
//   expired      one-cycle pulse at terminal count (registered)
//
// Load handshake: a transfer happens at a rising edge where load_valid and
// load_ready are both high. load_ready depends only on state and rst_n,
// never on load_valid. The requester holds load_value and auto_reload
// stable while load_valid is high, and may withdraw load_valid before a
// transfer.
module down_timer5 #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             stop,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expired
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             expired_q, expired_d;
  logic             accept;

  assign load_ready = rst_n && (state_q == IDLE);
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      mode_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      mode_q    <= mode_d;
      expired_q <= expired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    mode_d    = mode_q;
    expired_d = 1'b0;

    if (stop) begin
      // Abort wins over everything; the stored start value and mode survive.
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            reload_d = load_value;
            mode_d   = auto_reload;
            count_d  = load_value;
            if (load_value != '0) begin
              state_d = RUN;
            end else begin
              // A zero start value expires at once and never reloads.
              expired_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (en) begin
            // count is never 0 in RUN; <= keeps the decrement from wrapping
            // should that ever be violated.
            if (count_q <= WIDTH'(1)) begin
              expired_d = 1'b1;
              if (mode_q) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = IDLE;
              end
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  assign count   = count_q;
  assign busy    = (state_q == RUN);
  assign expired = expired_q;

endmodule
